// File: rtl/fetch_issue_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_issue_unit_pkg
// Shared definitions for the fetch/issue sequencer and the control decoder it
// drives. It holds the opcode constants, the instruction field layout and the
// sequencer state encodings.
// -----------------------------------------------------------------------------
package fetch_issue_unit_pkg;

    // Instruction layout: opcode in the top nibble, operand in the low 12 bits.
    localparam int INSTR_WIDTH   = 16;
    localparam int OPC_WIDTH     = 4;
    localparam int OPERAND_WIDTH = 12;
    localparam int OPC_LSB       = 12;

    // Opcode constants shared with the decoder.
    localparam logic [OPC_WIDTH-1:0] OPC_NOP  = 4'b0101;
    localparam logic [OPC_WIDTH-1:0] OPC_HALT = 4'b0111;

    // Sequencer state encodings. These are plain constants so that older tools
    // and the decoder can share the same values.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_HALTED = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

endpackage

// File: rtl/fetch_issue_unit_fetch_watchdog.sv
// -----------------------------------------------------------------------------
// fetch_issue_unit_fetch_watchdog
// This counter bounds how long a fetch may wait for instruction memory. It
// clears while clear is high and counts each cycle that enable is high. The
// expire output is asserted in the LIMIT-th enabled cycle after a clear.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset
//   clear   in   restart the count from zero
//   enable  in   count this cycle
//   expire  out  high in the final allowed cycle (combinational)
// -----------------------------------------------------------------------------
module fetch_issue_unit_fetch_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_reg;

    // The count stops at LAST. The owner leaves the waiting state on expire,
    // so the count never needs to wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && !expire) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = enable && (count_reg == LAST);

endmodule

// File: rtl/fetch_issue_unit.sv
// -----------------------------------------------------------------------------
// fetch_issue_unit
// This block sequences instruction fetch and issue for the control decoder. It
// fetches a word at pc and presents its opcode and operand while issue_valid is
// high. When the instruction retires, the block uses the decoder's ldpc and halt
// results to update pc. It also holds the halted and fetch-timeout fault status.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   run                       permit fetching (sampled in IDLE and at retire)
//   imem_req/imem_addr        fetch request and address (= pc)
//   imem_rdata/imem_valid     instruction word and strobe (used in FETCH only)
//   opcode/operand            decoder fields (NOP/0 outside ISSUE)
//   issue_valid               high in ISSUE
//   stall                     downstream busy, holds ISSUE
//   ldpc/halt/pc_target       decoder results, sampled at retire only
//   pc, halted, fault         status
//   instr_count               retired instruction count (wraps)
// -----------------------------------------------------------------------------
module fetch_issue_unit
    import fetch_issue_unit_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int INSTR_W       = 16,
    parameter int RESET_PC      = 0,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [3:0]         opcode,
    output logic [11:0]        operand,
    output logic               issue_valid,
    input  logic               stall,
    input  logic               ldpc,
    input  logic               halt,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        instr_count
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    logic [2:0]         state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [31:0]        count_reg, count_next;
    logic               wd_expire;

    // The watchdog is held clear outside FETCH. Each FETCH visit therefore
    // starts counting from zero.
    fetch_issue_unit_fetch_watchdog #(
        .LIMIT (FETCH_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg != ST_FETCH),
        .enable (state_reg == ST_FETCH),
        .expire (wd_expire)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Data arriving in the last allowed cycle still wins over the timeout.
                if (imem_valid) begin
                    instr_next = imem_rdata;
                    state_next = ST_ISSUE;
                end else if (wd_expire) begin
                    state_next = ST_FAULT;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    count_next = count_reg + 32'd1;
                    if (halt) begin
                        // pc keeps pointing at the HALT instruction.
                        state_next = ST_HALTED;
                    end else begin
                        pc_next    = ldpc ? pc_target : pc_reg + 1'b1;
                        state_next = run ? ST_FETCH : ST_IDLE;
                    end
                end
            end
            ST_HALTED, ST_FAULT: begin
                // These states are sticky. Only rst leaves them.
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= PC_INIT;
            instr_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            count_reg <= count_next;
        end
    end

    // Moore outputs decoded from the registered state.
    assign imem_req    = (state_reg == ST_FETCH);
    assign imem_addr   = pc_reg;
    assign issue_valid = (state_reg == ST_ISSUE);
    assign opcode      = issue_valid ? instr_reg[OPC_LSB +: OPC_WIDTH] : OPC_NOP;
    assign operand     = issue_valid ? instr_reg[OPERAND_WIDTH-1:0] : '0;
    assign pc          = pc_reg;
    assign halted      = (state_reg == ST_HALTED);
    assign fault       = (state_reg == ST_FAULT);
    assign instr_count = count_reg;

endmodule

// File: tb/tb_fetch_issue_unit.sv
module tb_fetch_issue_unit;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int NVEC    = 9;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               run = 1'b0;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               imem_valid = 1'b0;
    logic [3:0]         opcode;
    logic [11:0]        operand;
    logic               issue_valid;
    logic               stall = 1'b0;
    logic               ldpc = 1'b0;
    logic               halt = 1'b0;
    logic [ADDR_W-1:0]  pc_target = '0;
    logic [ADDR_W-1:0]  pc;
    logic               halted;
    logic               fault;
    logic [31:0]        instr_count;

    fetch_issue_unit #(
        .ADDR_W        (ADDR_W),
        .INSTR_W       (INSTR_W),
        .RESET_PC      (0),
        .FETCH_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .opcode      (opcode),
        .operand     (operand),
        .issue_valid (issue_valid),
        .stall       (stall),
        .ldpc        (ldpc),
        .halt        (halt),
        .pc_target   (pc_target),
        .pc          (pc),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  addr;
    } sb_t;

    typedef struct {
        logic [15:0] instr;
        logic        ldpc;
        logic        halt;
        logic [7:0]  target;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_next;
    } vec_t;

    sb_t         sb_q[$];
    vec_t        vecs[NVEC];
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          mem_mode = 0;   // 0: silent, 1: zero-wait memory, 2: strobe forced high
    logic [15:0] cur_word = '0;
    logic        prev_iv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Advance one clock. Sample just after the edge, check any newly issued word
    // against the scoreboard, then drive the memory response for the next edge.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (issue_valid && !prev_iv) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: issue with no fetched word (cycle %0d)", cycle);
            end else begin
                e = sb_q.pop_front();
                check("sb_opcode", 32'(opcode), 32'(e.word[15:12]));
                check("sb_operand", 32'(operand), 32'(e.word[11:0]));
                check("sb_pc", 32'(pc), 32'(e.addr));
                $display("issue cycle=%0d pc=%02h word=%04h opcode=%0h operand=%03h",
                         cycle, pc, e.word, opcode, operand);
            end
        end
        prev_iv = issue_valid;
        case (mem_mode)
            0:       imem_valid = 1'b0;
            1:       imem_valid = imem_req;
            default: imem_valid = 1'b1;
        endcase
        imem_rdata = (mem_mode == 1) ? cur_word : 16'h7FFF;
        if (imem_valid && imem_req) begin
            e.word = imem_rdata;
            e.addr = imem_addr;
            sb_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        prev_iv = 1'b0;
    endtask

    task automatic wait_issue(input int limit);
        int n = 0;
        while (!issue_valid && n < limit) begin
            tick();
            n++;
        end
        if (!issue_valid) begin
            total++;
            bad++;
            $display("FAIL wait_issue: no issue_valid within %0d cycles (cycle %0d)", limit, cycle);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Program walk: instr, ldpc, halt, target, fetch address, pc after retire.
        vecs[0] = '{16'h1234, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01};
        vecs[1] = '{16'h6005, 1'b1, 1'b0, 8'h05, 8'h01, 8'h05};
        vecs[2] = '{16'h6020, 1'b1, 1'b0, 8'h20, 8'h05, 8'h20};
        vecs[3] = '{16'h6005, 1'b1, 1'b0, 8'h05, 8'h20, 8'h05};
        vecs[4] = '{16'h8004, 1'b0, 1'b0, 8'hAA, 8'h05, 8'h06};
        vecs[5] = '{16'h60FF, 1'b1, 1'b0, 8'hFF, 8'h06, 8'hFF};
        vecs[6] = '{16'h2ABC, 1'b0, 1'b0, 8'h11, 8'hFF, 8'h00};
        vecs[7] = '{16'h6003, 1'b1, 1'b0, 8'h03, 8'h00, 8'h03};
        vecs[8] = '{16'h7000, 1'b1, 1'b1, 8'h40, 8'h03, 8'h03};

        // Reset state
        do_reset();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_opcode", 32'(opcode), 32'h5);
        check("rst_operand", 32'(operand), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_count", instr_count, 32'd0);

        // First fetch: request one cycle after run, issue on the next cycle
        run = 1'b1;
        mem_mode = 1;
        cur_word = 16'h0123;
        tick();
        check("t1_imem_req", 32'(imem_req), 32'd1);
        check("t1_imem_addr", 32'(imem_addr), 32'd0);
        tick();
        check("t1_issue_valid", 32'(issue_valid), 32'd1);
        check("t1_opcode", 32'(opcode), 32'h0);
        check("t1_operand", 32'(operand), 32'h123);
        run = 1'b0;
        tick();
        check("t1_pc", 32'(pc), 32'd1);
        check("t1_count", instr_count, 32'd1);
        check("t1_idle_issue", 32'(issue_valid), 32'd0);
        tick();
        check("t1_idle_req", 32'(imem_req), 32'd0);

        // Table-driven program: jumps, not-taken branch, pc wrap, halt beats ldpc
        do_reset();
        run = 1'b1;
        cur_word = vecs[0].instr;
        for (int i = 0; i < NVEC; i++) begin
            wait_issue(10);
            check("vec_addr", 32'(pc), 32'(vecs[i].exp_addr));
            check("vec_opcode", 32'(opcode), 32'(vecs[i].instr[15:12]));
            check("vec_operand", 32'(operand), 32'(vecs[i].instr[11:0]));
            ldpc = vecs[i].ldpc;
            halt = vecs[i].halt;
            pc_target = vecs[i].target;
            cur_word = (i + 1 < NVEC) ? vecs[i + 1].instr : 16'h0000;
            tick();
            ldpc = 1'b0;
            halt = 1'b0;
            check("vec_pc_next", 32'(pc), 32'(vecs[i].exp_next));
            check("vec_count", instr_count, 32'(i + 1));
        end

        // HALTED is sticky with run held high
        for (int k = 0; k < 12; k++) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_pc", 32'(pc), 32'h03);
            tick();
        end
        run = 1'b0;
        do_reset();
        check("halt_rst_pc", 32'(pc), 32'd0);
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_req", 32'(imem_req), 32'd0);
        check("halt_rst_count", instr_count, 32'd0);

        // Fetch timeout: eight silent FETCH cycles lead to FAULT
        run = 1'b1;
        mem_mode = 0;
        for (int k = 0; k < 8; k++) tick();
        check("to_req_8th", 32'(imem_req), 32'd1);
        check("to_fault_8th", 32'(fault), 32'd0);
        tick();
        check("to_fault", 32'(fault), 32'd1);
        check("to_fault_req", 32'(imem_req), 32'd0);
        tick();
        tick();
        check("to_fault_held", 32'(fault), 32'd1);
        check("to_fault_pc", 32'(pc), 32'd0);

        // Data in the final allowed cycle wins over the timeout
        run = 1'b0;
        do_reset();
        run = 1'b1;
        mem_mode = 0;
        for (int k = 0; k < 7; k++) tick();
        mem_mode = 1;
        cur_word = 16'h4321;
        tick();
        tick();
        check("to_late_fault", 32'(fault), 32'd0);
        check("to_late_issue", 32'(issue_valid), 32'd1);

        // Stall holds ISSUE; pc 0xFF increments and wraps to 0
        run = 1'b0;
        do_reset();
        run = 1'b1;
        mem_mode = 1;
        cur_word = 16'h60FF;
        wait_issue(10);
        ldpc = 1'b1;
        pc_target = 8'hFF;
        cur_word = 16'h3456;
        tick();
        ldpc = 1'b0;
        check("st_pc_ff", 32'(pc), 32'hFF);
        wait_issue(10);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("st_issue_valid", 32'(issue_valid), 32'd1);
            check("st_opcode", 32'(opcode), 32'h3);
            check("st_operand", 32'(operand), 32'h456);
            check("st_count", instr_count, 32'd1);
            check("st_pc", 32'(pc), 32'hFF);
        end
        stall = 1'b0;
        run = 1'b0;
        tick();
        check("st_wrap_pc", 32'(pc), 32'd0);
        check("st_count_once", instr_count, 32'd2);
        check("st_to_idle", 32'(issue_valid), 32'd0);
        tick();
        check("st_idle_req", 32'(imem_req), 32'd0);

        // Reset during FETCH; a strobe after reset is ignored
        do_reset();
        run = 1'b1;
        mem_mode = 0;
        tick();
        check("mr_req", 32'(imem_req), 32'd1);
        mem_mode = 2;
        do_reset();
        run = 1'b0;
        tick();
        check("mr_issue", 32'(issue_valid), 32'd0);
        check("mr_req_idle", 32'(imem_req), 32'd0);
        check("mr_pc", 32'(pc), 32'd0);
        check("mr_opcode", 32'(opcode), 32'h5);
        tick();
        check("mr_issue2", 32'(issue_valid), 32'd0);
        check("mr_count", instr_count, 32'd0);
        mem_mode = 0;
        tick();

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
